// File: rtl/vga_pkg.sv
// vga_pkg: VGA mode constants, sync polarity and monitor state encoding shared by generator and monitor.
package vga_pkg;
   localparam int VGA_H_SYNC = 96;
   localparam int VGA_H_BP = 48;
   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_TOTAL = 800;
   localparam int VGA_V_SYNC = 2;
   localparam int VGA_V_BP = 33;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_TOTAL = 525;
   localparam int VGA_CW = 11;
   localparam logic VGA_SYNC_POL = 1'b0;
   typedef enum logic [1:0] {HUNT = 2'd0, SYNC = 2'd1, LOCKED = 2'd2} vga_state_t;
   function automatic logic in_win(input int v, input int lo, input int len);
      return v >= lo && v < lo + len;
   endfunction
endpackage

// File: rtl/vga_sync_meter.sv
// vga_sync_meter: edge detect, position counter and period/width measurement for one sync signal.
module vga_sync_meter #(
   parameter int PERIOD = 800,
   parameter int WIDTH = 96,
   parameter int CW = 11,
   parameter logic POL = 1'b0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          tick,
   input  logic          pulse,
   input  logic          inc,
   output logic          sync_edge,
   output logic          sync_fall,
   output logic [CW-1:0] cnt,
   output logic          period_ok,
   output logic          width_ok
);
   logic act, prev;
   logic [CW-1:0] cnt_q, wid;
   assign act = pulse == POL;
   assign sync_edge = tick & act & ~prev;
   assign sync_fall = tick & ~act & prev;
   // cnt is the position of the current tick, so callers see the updated value combinationally
   assign cnt = sync_edge ? '0 : (inc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
   assign period_ok = int'(cnt_q) + 1 == PERIOD;
   assign width_ok = int'(wid) == WIDTH;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         prev <= 1'b0;
         cnt_q <= '0;
         wid <= '0;
      end else if (tick) begin
         prev <= act;
         cnt_q <= cnt;
         wid <= sync_edge ? CW'(1) : (act && inc && wid != '1) ? wid + 1'b1 : wid;
      end
endmodule

// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: loopback checker for VGA timing; reports lock, sticky timing errors,
// per-frame pixel checksum and locked frame count.
module vga_sync_monitor import vga_pkg::*; #(
   parameter int H_SYNC = VGA_H_SYNC,
   parameter int H_BP = VGA_H_BP,
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_TOTAL = VGA_H_TOTAL,
   parameter int V_SYNC = VGA_V_SYNC,
   parameter int V_BP = VGA_V_BP,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_TOTAL = VGA_V_TOTAL,
   parameter logic SYNC_POL = VGA_SYNC_POL,
   parameter int CW = VGA_CW
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pix_en,
   input  logic        hsync,
   input  logic        vsync,
   input  logic [3:0]  rdata,
   input  logic [3:0]  gdata,
   input  logic [3:0]  bdata,
   input  logic        clr_err,
   output logic        locked,
   output logic        frame_done,
   output logic [23:0] frame_sum,
   output logic [15:0] frame_cnt,
   output logic        err_hper,
   output logic        err_hsw,
   output logic        err_vper,
   output logic        err_vsw
);
   logic h_edge, h_fall, h_per_ok, h_w_ok, v_edge, v_fall, v_per_ok, v_w_ok;
   logic [CW-1:0] h_cnt, v_cnt;
   vga_sync_meter #(.PERIOD(H_TOTAL), .WIDTH(H_SYNC), .CW(CW), .POL(SYNC_POL)) u_h (
      .clk(clk), .rst(rst), .tick(pix_en), .pulse(hsync), .inc(pix_en),
      .sync_edge(h_edge), .sync_fall(h_fall), .cnt(h_cnt), .period_ok(h_per_ok), .width_ok(h_w_ok)
   );
   vga_sync_meter #(.PERIOD(V_TOTAL), .WIDTH(V_SYNC), .CW(CW), .POL(SYNC_POL)) u_v (
      .clk(clk), .rst(rst), .tick(pix_en), .pulse(vsync), .inc(h_edge),
      .sync_edge(v_edge), .sync_fall(v_fall), .cnt(v_cnt), .period_ok(v_per_ok), .width_ok(v_w_ok)
   );
   vga_state_t state, state_nxt;
   logic h_chk, bad, chk, e_hper, e_hsw, e_vper, e_vsw, any_err, active, done, lk;
   logic [23:0] acc;
   assign chk = state != HUNT;
   assign lk = state == LOCKED;
   assign locked = lk;
   // h_chk skips the first, possibly partial, line after leaving HUNT
   assign e_hper = chk & h_chk & h_edge & ~h_per_ok;
   assign e_hsw = chk & h_fall & ~h_w_ok;
   assign e_vper = chk & v_edge & ~v_per_ok;
   assign e_vsw = chk & v_fall & ~v_w_ok;
   assign any_err = e_hper | e_hsw | e_vper | e_vsw;
   assign active = pix_en && in_win(int'(h_cnt), H_SYNC + H_BP, H_ACTIVE)
                          && in_win(int'(v_cnt), V_SYNC + V_BP, V_ACTIVE);
   always_comb begin
      state_nxt = state;
      done = 1'b0;
      if (state == HUNT) state_nxt = v_edge ? SYNC : HUNT;
      else if (state == SYNC) state_nxt = (v_edge && !bad && !any_err) ? LOCKED : SYNC;
      else begin
         state_nxt = any_err ? HUNT : LOCKED;
         done = v_edge && !any_err;
      end
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= HUNT;
         h_chk <= 1'b0;
         bad <= 1'b0;
         acc <= '0;
         frame_done <= 1'b0;
         frame_sum <= '0;
         frame_cnt <= '0;
         err_hper <= 1'b0;
         err_hsw <= 1'b0;
         err_vper <= 1'b0;
         err_vsw <= 1'b0;
      end else begin
         state <= state_nxt;
         h_chk <= state == HUNT ? 1'b0 : h_edge ? 1'b1 : h_chk;
         bad <= (state != SYNC || v_edge) ? 1'b0 : bad | any_err;
         acc <= (state == HUNT || v_edge) ? '0 : active ? acc + {12'd0, rdata, gdata, bdata} : acc;
         frame_done <= done;
         frame_sum <= done ? acc : frame_sum;
         frame_cnt <= done ? frame_cnt + 1'b1 : frame_cnt;
         err_hper <= (err_hper & ~clr_err) | (lk & e_hper);
         err_hsw <= (err_hsw & ~clr_err) | (lk & e_hsw);
         err_vper <= (err_vper & ~clr_err) | (lk & e_vper);
         err_vsw <= (err_vsw & ~clr_err) | (lk & e_vsw);
      end
endmodule

// File: tb/tb_vga_sync_monitor.sv
// tb_vga_sync_monitor: directed frame table in a 10x8 mode plus reset-mid-frame sequence.
module tb_vga_sync_monitor;
   logic clk = 1'b0, rst = 1'b1, pix_en = 1'b0, hsync = 1'b1, vsync = 1'b1, clr_err = 1'b0;
   logic [3:0] rdata = '0, gdata = '0, bdata = '0;
   logic locked, frame_done, err_hper, err_hsw, err_vper, err_vsw;
   logic [23:0] frame_sum;
   logic [15:0] frame_cnt;
   int checks = 0, failures = 0, done_cnt = 0, wide_cnt = 0;
   logic prev_done = 1'b0;

   vga_sync_monitor #(
      .H_SYNC(2), .H_BP(1), .H_ACTIVE(4), .H_TOTAL(10),
      .V_SYNC(1), .V_BP(1), .V_ACTIVE(3), .V_TOTAL(8), .SYNC_POL(1'b0), .CW(11)
   ) dut (
      .clk(clk), .rst(rst), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
      .rdata(rdata), .gdata(gdata), .bdata(bdata), .clr_err(clr_err),
      .locked(locked), .frame_done(frame_done), .frame_sum(frame_sum), .frame_cnt(frame_cnt),
      .err_hper(err_hper), .err_hsw(err_hsw), .err_vper(err_vper), .err_vsw(err_vsw)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_done) begin
         done_cnt++;
         if (prev_done) wide_cnt++;
      end
      prev_done = frame_done;
   end

   typedef struct {
      logic [11:0] pix;
      int          short_line;
      int          vs_lines;
      int          gap;
      logic        clr;
      logic        exp_locked;
      int          exp_cnt;
      int          exp_sum;
      int          exp_done;
      logic [3:0]  exp_err;
   } row_t;
   row_t rows[15];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic put(input logic hs, input logic vs, input logic [11:0] p, input int gap);
      @(negedge clk);
      hsync = ~hs;
      vsync = ~vs;
      {rdata, gdata, bdata} = p;
      pix_en = 1'b1;
      repeat (gap) begin
         @(negedge clk);
         pix_en = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         pix_en = 1'b0;
      end
   endtask

   task automatic frame(input logic [11:0] pa, input int short_line, input int vs_lines,
                        input int gap, input int maxpix);
      int n = 0;
      for (int vl = 0; vl < 8; vl++)
         for (int hp = 0; hp < (vl == short_line ? 9 : 10); hp++)
            if (n < maxpix) begin
               put(hp < 2, vl < vs_lines,
                   (hp >= 3 && hp < 7 && vl >= 2 && vl < 5) ? pa : 12'h555, gap);
               n++;
            end
   endtask

   task automatic check_status(input string tag, input logic lk, input int cnt, input int sum,
                               input int dn, input logic [3:0] err);
      check({tag, " locked"}, 32'(locked), 32'(lk));
      check({tag, " frame_cnt"}, 32'(frame_cnt), cnt);
      check({tag, " frame_sum"}, 32'(frame_sum), sum);
      check({tag, " done_pulses"}, done_cnt, dn);
      check({tag, " errs"}, 32'({err_hper, err_hsw, err_vper, err_vsw}), 32'(err));
   endtask

   initial begin
      rows[0]  = '{12'h001, -1, 1, 0, 1'b0, 1'b0, 0, 0,     0, 4'b0000};
      rows[1]  = '{12'h001, -1, 1, 0, 1'b0, 1'b1, 0, 0,     0, 4'b0000};
      rows[2]  = '{12'h001, -1, 1, 0, 1'b0, 1'b1, 1, 12,    1, 4'b0000};
      rows[3]  = '{12'hFFF, -1, 1, 0, 1'b0, 1'b1, 2, 12,    2, 4'b0000};
      rows[4]  = '{12'hFFF, -1, 1, 0, 1'b0, 1'b1, 3, 49140, 3, 4'b0000};
      rows[5]  = '{12'hFFF,  3, 1, 0, 1'b0, 1'b0, 4, 49140, 4, 4'b1000};
      rows[6]  = '{12'h001, -1, 1, 0, 1'b0, 1'b0, 4, 49140, 4, 4'b1000};
      rows[7]  = '{12'h001, -1, 1, 0, 1'b0, 1'b1, 4, 49140, 4, 4'b1000};
      rows[8]  = '{12'h001, -1, 1, 0, 1'b1, 1'b1, 5, 12,    5, 4'b0000};
      rows[9]  = '{12'h001, -1, 2, 0, 1'b0, 1'b0, 6, 12,    6, 4'b0001};
      rows[10] = '{12'h001, -1, 1, 2, 1'b0, 1'b0, 6, 12,    6, 4'b0001};
      rows[11] = '{12'h001, -1, 1, 2, 1'b0, 1'b1, 6, 12,    6, 4'b0001};
      rows[12] = '{12'h001, -1, 1, 2, 1'b0, 1'b1, 7, 12,    7, 4'b0001};
      rows[13] = '{12'hFFF, -1, 1, 2, 1'b0, 1'b1, 8, 12,    8, 4'b0001};
      rows[14] = '{12'hFFF, -1, 1, 2, 1'b0, 1'b1, 9, 49140, 9, 4'b0001};

      repeat (3) @(negedge clk);
      check_status("reset", 1'b0, 0, 0, 0, 4'b0000);
      check("reset frame_done", 32'(frame_done), 0);
      rst = 1'b0;
      idle(2);

      for (int i = 0; i < 15; i++) begin
         if (rows[i].clr) begin
            @(negedge clk);
            clr_err = 1'b1;
            @(negedge clk);
            clr_err = 1'b0;
         end
         frame(rows[i].pix, rows[i].short_line, rows[i].vs_lines, rows[i].gap, 80);
         idle(2);
         check_status($sformatf("row%0d", i), rows[i].exp_locked, rows[i].exp_cnt,
                      rows[i].exp_sum, rows[i].exp_done, rows[i].exp_err);
      end

      frame(12'hFFF, -1, 1, 0, 35);
      idle(1);
      check_status("pre_rst", 1'b1, 10, 49140, 10, 4'b0001);
      #2 rst = 1'b1;
      #1;
      check_status("mid_rst", 1'b0, 0, 0, 10, 4'b0000);
      check("mid_rst frame_done", 32'(frame_done), 0);
      @(negedge clk);
      rst = 1'b0;
      idle(3);
      check("post_rst done_pulses", done_cnt, 10);

      frame(12'hFFF, -1, 1, 0, 80);
      idle(2);
      check_status("relock_a", 1'b0, 0, 0, 10, 4'b0000);
      frame(12'hFFF, -1, 1, 0, 80);
      idle(2);
      check_status("relock_b", 1'b1, 0, 0, 10, 4'b0000);
      frame(12'hFFF, -1, 1, 0, 80);
      idle(2);
      check_status("relock_c", 1'b1, 1, 49140, 11, 4'b0000);
      check("frame_done width", wide_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/vga_sync_monitor.md
Name: vga_sync_monitor

Overview:
- Receive-side counterpart of the board's VGA output. Consumes hsync/vsync/rdata/gdata/bdata and checks the timing against the configured mode.
- Reports lock, sticky timing errors, a per-frame pixel checksum and a frame count.
- Instantiated in the zedboard top as a loopback checker on the VGA pins. Its status is readable by the core/testbench, so display output is self-checking without waveform inspection.

Parameters:
H_SYNC, 96, hsync pulse width in pixels
H_BP, 48, horizontal back porch in pixels
H_ACTIVE, 640, visible pixels per line
H_TOTAL, 800, pixels per line
V_SYNC, 2, vsync pulse width in lines
V_BP, 33, vertical back porch in lines
V_ACTIVE, 480, visible lines
V_TOTAL, 525, lines per frame
SYNC_POL, 0, sync assert level (0 = active-low)
CW, 11, width of h/v counters

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
pix_en  in  1  pixel-rate strobe; all sampling occurs only on clk edges with pix_en=1
hsync  in  1  horizontal sync from VGA generator
vsync  in  1  vertical sync from VGA generator
rdata  in  4  red
gdata  in  4  green
bdata  in  4  blue
clr_err  in  1  clears sticky error flags (single-cycle pulse)
locked  out  1  timing lock indicator
frame_done  out  1  one-clk pulse at end of each locked frame
frame_sum  out  24  sum of {rdata,gdata,bdata} over active region of last frame
frame_cnt  out  16  locked frames completed, wraps at 65535->0
err_hper  out  1  sticky: line length != H_TOTAL
err_hsw  out  1  sticky: hsync width != H_SYNC
err_vper  out  1  sticky: lines per frame != V_TOTAL
err_vsw  out  1  sticky: vsync width != V_SYNC

Behaviour:
- Reset value of every output, counter and state is 0. State resets to HUNT.
- Inputs hs/vs are normalised: asserted = (pin == SYNC_POL). Previous levels are registered on pix_en ticks.
- Assert edge is a tick where the sync is asserted and its previous level was deasserted.
- h_cnt:
  - 0 on the hsync assert-edge tick, else +1 per tick.
  - Saturates at 2^CW-1.
- v_cnt:
  - +1 on each hsync assert-edge tick.
  - 0 on the vsync assert-edge tick; vsync wins if both edges occur on the same tick.
- hsync width is counted while hs is asserted and compared on the deassert tick. vsync width, in lines, is compared the same way.
- Line-length check: on an hsync assert edge, (previous h_cnt + 1) must equal H_TOTAL. The first line after HUNT is not checked.
- Frame-length check: on a vsync assert edge, (previous v_cnt + 1) must equal V_TOTAL.
- Active pixel condition:
  - H_SYNC+H_BP <= h_cnt < H_SYNC+H_BP+H_ACTIVE, and
  - V_SYNC+V_BP <= v_cnt < V_SYNC+V_BP+V_ACTIVE.
  - The 12-bit pixel {r,g,b} is added to a 24-bit accumulator modulo 2^24.
- State machine:
  - HUNT: checks disabled, accumulator held at 0. On vsync assert edge -> SYNC.
  - SYNC: checks active; errors are internal only and do not set sticky flags.
    - On the next vsync edge with no internal error in the frame -> LOCKED, locked=1 from the next clk.
    - Otherwise remain in SYNC and restart the frame.
  - LOCKED: on any check failure, set the matching sticky flag, drop locked the next clk, go to HUNT.
  - LOCKED, on a vsync assert edge with no failure:
    - frame_done=1 for exactly one clk.
    - frame_sum <= accumulator; accumulator cleared.
    - frame_cnt += 1.
- The frame-closing vsync edge of the SYNC->LOCKED transition does not produce frame_done. The first frame_done comes one full frame later.
- Errors that occur in the same tick as frame completion set their flag, and frame_done is suppressed.
- clr_err clears all sticky flags. If a new error occurs in the same cycle, the new error wins (flag = 1).
- pix_en=0: all state is frozen and frame_done stays 0.
- rst mid-frame returns everything to reset values immediately, with no partial frame_done.

Decomposition:
- Shared package vga_pkg holds the VGA mode constants, the state encoding (HUNT/SYNC/LOCKED) and the sync-polarity constant. The VGA generator and this monitor both import it.
- One sub-module, vga_sync_meter, instantiated twice (horizontal, vertical):
  - Inputs: the strobe and the pulse signal.
  - Outputs: edge, period_ok and width_ok, against parameterised PERIOD/WIDTH.
- Top holds the FSM, accumulator and sticky flags.

Test Plan:
- Small mode (H_SYNC=2, H_BP=1, H_ACTIVE=4, H_TOTAL=10, V_SYNC=1, V_BP=1, V_ACTIVE=3, V_TOTAL=8), pix_en=1, ideal timing, constant pixel 12'h001 -> locked=1 after 2nd vsync edge; first frame_done at 3rd edge with frame_sum=12, frame_cnt=1.
- Same mode, pixel 12'hFFF -> frame_sum=12*4095=49140 each frame. Non-active pixels driven 12'h555 contribute 0.
- Locked, one line shortened to 9 pixels -> err_hper=1, locked=0 next clk, no frame_done that frame; relock after 2 good frames. clr_err -> err_hper=0.
- Locked, vsync held 2 lines -> err_vsw=1, state HUNT; frame_cnt unchanged.
- pix_en asserted 1 in 3 clks with the ideal stream -> identical frame_sum/frame_cnt to the pix_en=1 case; frame_done width exactly 1 clk.
- rst pulsed mid-frame while locked -> all outputs 0 on the same clk, no frame_done. Relock after 2 frames; frame_cnt restarts at 1.
